// File: rtl/traffic_pkg.sv
// Shared lamp encodings, lamp indices and fault codes for the T-intersection controller,
// its safety monitor and their benches.
package traffic_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [1:0] M1     = 2'd0;
  localparam logic [1:0] SIDE   = 2'd1;
  localparam logic [1:0] M2     = 2'd2;
  localparam logic [1:0] M1TURN = 2'd3;

  localparam int unsigned NumLamps = 4;

  typedef enum logic [2:0] {
    FcNone     = 3'd0,
    FcEncoding = 3'd1,
    FcConflict = 3'd2,
    FcSequence = 3'd3,
    FcYShort   = 3'd4,
    FcYLong    = 3'd5,
    FcGShort   = 3'd6
  } fault_code_e;

  function automatic logic is_onehot3(logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

endpackage

// File: rtl/lamp_phase_checker.sv
// Per-lamp colour history: remembers the previous sample and its dwell, and flags encoding,
// sequence and green/yellow timing violations for the current sample.
module lamp_phase_checker
  import traffic_pkg::*;
#(
  parameter int unsigned G_MIN = 10,
  parameter int unsigned Y_MIN = 3,
  parameter int unsigned Y_MAX = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_valid_i,
  input  logic [2:0] s_i,
  output logic       enc_err_o,
  output logic       seq_err_o,
  output logic       g_short_o,
  output logic       y_short_o,
  output logic       y_long_o,
  output logic       active_o
);

  logic [2:0]       p_q, p_d;
  logic             p_valid_q, p_valid_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             y_rep_q, y_rep_d;
  logic             s_ok, chk, hold, legal;

  always_comb begin
    s_ok  = s_valid_i && is_onehot3(s_i);
    chk   = s_ok && p_valid_q;
    hold  = (s_i == p_q);
    legal = hold || ((p_q == RED) && (s_i == GRN)) || ((p_q == GRN) && (s_i == YEL)) ||
            ((p_q == YEL) && (s_i == RED));

    enc_err_o = s_valid_i && !is_onehot3(s_i);
    active_o  = s_ok && ((s_i == GRN) || (s_i == YEL));
    seq_err_o = chk && !legal;
    g_short_o = chk && (p_q == GRN) && (s_i == YEL) && (dwell_q < CNT_W'(G_MIN));
    y_short_o = chk && (p_q == YEL) && (s_i == RED) && (dwell_q < CNT_W'(Y_MIN));

    p_d       = p_q;
    p_valid_d = p_valid_q;
    dwell_d   = dwell_q;
    if (s_valid_i) begin
      if (s_ok) begin
        p_d       = s_i;
        p_valid_d = 1'b1;
        if (p_valid_q && hold) begin
          dwell_d = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);
        end else begin
          dwell_d = CNT_W'(1);
        end
      end else begin
        // A malformed sample breaks the history; the next good sample starts afresh.
        p_valid_d = 1'b0;
        dwell_d   = '0;
      end
    end

    y_long_o = chk && hold && (s_i == YEL) && (dwell_d >= CNT_W'(Y_MAX + 1)) && !y_rep_q;

    y_rep_d = y_rep_q;
    if (y_long_o) begin
      y_rep_d = 1'b1;
    end else if (!(s_ok && (s_i == YEL))) begin
      y_rep_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q       <= '0;
      p_valid_q <= 1'b0;
      dwell_q   <= '0;
      y_rep_q   <= 1'b0;
    end else begin
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      dwell_q   <= dwell_d;
      y_rep_q   <= y_rep_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor on the four intersection lamps: registers the lamps, runs per-lamp and
// cross-lamp checks, and latches the first fault while strobing and counting every one.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned G_MIN = 10,
  parameter int unsigned Y_MIN = 3,
  parameter int unsigned Y_MAX = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_Side,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_M1Turn,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_lamp,
  output logic       fault_pulse,
  output logic [7:0] fault_cnt
);

  logic [2:0] s_q [NumLamps];
  logic       s_valid_q;

  logic [NumLamps-1:0] enc_err, seq_err, g_short, y_short, y_long, active, conf;
  logic [NumLamps-1:0] err_by_code [7];

  logic        det_any;
  fault_code_e det_code;
  logic [1:0]  det_lamp;

  logic        fault_q, fault_d;
  fault_code_e code_q, code_d;
  logic [1:0]  lamp_q, lamp_d;
  logic        pulse_q, pulse_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumLamps; i++) s_q[i] <= RED;
      s_valid_q <= 1'b0;
    end else begin
      s_q[M1]     <= light_M1;
      s_q[SIDE]   <= light_Side;
      s_q[M2]     <= light_M2;
      s_q[M1TURN] <= light_M1Turn;
      s_valid_q   <= 1'b1;
    end
  end

  for (genvar g = 0; g < NumLamps; g++) begin : gen_lamp
    lamp_phase_checker #(
      .G_MIN(G_MIN),
      .Y_MIN(Y_MIN),
      .Y_MAX(Y_MAX),
      .CNT_W(CNT_W)
    ) u_chk (
      .clk_i    (clk),
      .rst_i    (rst),
      .s_valid_i(s_valid_q),
      .s_i      (s_q[g]),
      .enc_err_o(enc_err[g]),
      .seq_err_o(seq_err[g]),
      .g_short_o(g_short[g]),
      .y_short_o(y_short[g]),
      .y_long_o (y_long[g]),
      .active_o (active[g])
    );
  end

  always_comb begin
    // Conflicts are attributed to the lower-index lamp of the pair.
    conf         = '0;
    conf[M1]     = active[M1] && active[SIDE];
    conf[SIDE]   = active[SIDE] && (active[M2] || active[M1TURN]);
    conf[M2]     = active[M2] && active[M1TURN];

    err_by_code[0] = '0;
    err_by_code[1] = enc_err;
    err_by_code[2] = conf;
    err_by_code[3] = seq_err;
    err_by_code[4] = y_short;
    err_by_code[5] = y_long;
    err_by_code[6] = g_short;

    det_any  = 1'b0;
    det_code = FcNone;
    det_lamp = '0;
    // Scan from the lowest priority upward so the last hit is the winner.
    for (int c = 6; c >= 1; c--) begin
      for (int l = NumLamps - 1; l >= 0; l--) begin
        if (err_by_code[c][l]) begin
          det_any  = 1'b1;
          det_code = fault_code_e'(c[2:0]);
          det_lamp = l[1:0];
        end
      end
    end
  end

  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    lamp_d  = lamp_q;
    cnt_d   = cnt_q;
    pulse_d = det_any;
    if (fault_clr) begin
      fault_d = det_any;
      code_d  = det_any ? det_code : FcNone;
      lamp_d  = det_any ? det_lamp : 2'd0;
      cnt_d   = det_any ? 8'd1 : 8'd0;
    end else if (det_any) begin
      cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
      if (!fault_q) begin
        fault_d = 1'b1;
        code_d  = det_code;
        lamp_d  = det_lamp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
      code_q  <= FcNone;
      lamp_q  <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fault_q <= fault_d;
      code_q  <= code_d;
      lamp_q  <= lamp_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_lamp  = lamp_q;
  assign fault_pulse = pulse_q;
  assign fault_cnt   = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: legal signalling plus one scenario per fault class.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] m1 = R, side = R, m2 = R, turn = R;
  logic       fault, fault_pulse;
  logic [2:0] fault_code;
  logic [1:0] fault_lamp;
  logic [7:0] fault_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .light_M1    (m1),
    .light_Side  (side),
    .light_M2    (m2),
    .light_M1Turn(turn),
    .fault_clr   (clr),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_lamp  (fault_lamp),
    .fault_pulse (fault_pulse),
    .fault_cnt   (fault_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_l(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] d);
    m1 = a; side = b; m2 = c; turn = d;
  endtask

  task automatic do_reset();
    set_l(R, R, R, R);
    clr = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic check_outs(input string tag, input logic f, input logic [2:0] c,
                            input logic [1:0] l, input logic [7:0] n);
    check({tag, ".fault"}, fault, f);
    check({tag, ".code"}, fault_code, c);
    check({tag, ".lamp"}, fault_lamp, l);
    check({tag, ".cnt"}, fault_cnt, n);
  endtask

  int pulses, pulse_at;

  initial begin
    tick(2);
    check_outs("reset", 1'b0, 3'd0, 2'd0, 8'd0);
    check("reset.pulse", fault_pulse, 1'b0);
    rst = 1'b0;
    tick(2);

    // Legal cycle: main roads, then side road.
    set_l(G, R, G, R); tick(12);
    set_l(Y, R, Y, R); tick(4);
    set_l(R, R, R, R); tick(2);
    set_l(R, G, R, R); tick(12);
    set_l(R, Y, R, R); tick(4);
    set_l(R, R, R, R); tick(3);
    check_outs("legal", 1'b0, 3'd0, 2'd0, 8'd0);

    // Side green against M1 green.
    do_reset();
    set_l(G, G, R, R); tick(2);
    check_outs("conflict", 1'b1, 3'd2, 2'd0, 8'd1);
    check("conflict.pulse", fault_pulse, 1'b1);
    tick(1);
    check("conflict.cnt2", fault_cnt, 8'd2);
    clr = 1'b1; tick(1); clr = 1'b0;
    check_outs("clr_same_edge", 1'b1, 3'd2, 2'd0, 8'd1);

    // Turn lamp green straight to red.
    do_reset();
    set_l(R, R, R, G); tick(3);
    set_l(R, R, R, R); tick(2);
    check_outs("seq", 1'b1, 3'd3, 2'd3, 8'd1);

    // M2 green too short.
    do_reset();
    set_l(R, R, G, R); tick(5);
    set_l(R, R, Y, R); tick(2);
    check_outs("g_short", 1'b1, 3'd6, 2'd2, 8'd1);

    // M2 yellow too short.
    do_reset();
    set_l(R, R, G, R); tick(12);
    set_l(R, R, Y, R); tick(2);
    set_l(R, R, R, R); tick(2);
    check_outs("y_short", 1'b1, 3'd4, 2'd2, 8'd1);

    // M1 yellow held 9 cycles: one pulse only, from the 6th yellow sample.
    do_reset();
    set_l(G, R, R, R); tick(12);
    set_l(Y, R, R, R);
    pulses = 0; pulse_at = 0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 10) set_l(R, R, R, R);
      tick(1);
      if (fault_pulse) begin
        pulses++;
        if (pulse_at == 0) pulse_at = i;
      end
    end
    check("y_long.pulses", pulses, 1);
    check("y_long.pulse_at", pulse_at, 7);
    check_outs("y_long", 1'b1, 3'd5, 2'd0, 8'd1);

    // Malformed side lamp together with an M2/turn conflict, then clear.
    do_reset();
    set_l(R, 3'b011, G, G); tick(1);
    set_l(R, R, R, R); tick(1);
    check_outs("enc", 1'b1, 3'd1, 2'd1, 8'd1);
    check("enc.pulse", fault_pulse, 1'b1);
    tick(1);
    check("enc.later_cnt", fault_cnt, 8'd2);
    check("enc.first_wins", fault_code, 3'd1);
    tick(1);
    check("enc.quiet_pulse", fault_pulse, 1'b0);
    clr = 1'b1; tick(1); clr = 1'b0;
    check_outs("clr", 1'b0, 3'd0, 2'd0, 8'd0);

    // Reset in the middle of a yellow interval wipes the dwell history.
    do_reset();
    set_l(G, R, R, R); tick(12);
    set_l(Y, R, R, R); tick(4);
    rst = 1'b1; tick(1); rst = 1'b0;
    tick(4);
    set_l(R, R, R, R); tick(3);
    check_outs("rst_mid_yellow", 1'b0, 3'd0, 2'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
